hazard_unit: RTL and testbench

Stall and flush controller for the 5-stage pipeline; the counterpart of the forwarding unit. Where forwarding cannot resolve a dependency, this block holds or bubbles the pipeline: load-use hazards, taken-branch flushes, and multi-cycle data-memory waits. A small FSM, a watchdog and performance counters make it sequential. It sits beside the forwarding unit, reads the IF/ID, ID/EX and EX/MEM register outputs, and drives every pipeline-register write enable.

---
 rtl/hazard_unit_pkg.sv | 23 ++
 rtl/hazard_unit_sat_counter.sv | 24 ++
 rtl/hazard_unit.sv | 95 +++++++++
 tb/tb_hazard_unit.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// hazard_unit_pkg: shared register-number width, hazard FSM states and load-use helper
package hazard_unit_pkg;

    localparam int REG_NUM_W = 5;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_MEM_WAIT = 2'd1,
        HZ_ERROR    = 2'd2
    } hz_state_e;

    // A load in EX feeds a source of the ID instruction; $zero never creates a dependency
    function automatic logic load_use_hit(
        input logic                 is_load,
        input logic [REG_NUM_W-1:0] rd,
        input logic [REG_NUM_W-1:0] rs,
        input logic [REG_NUM_W-1:0] rt,
        input logic                 uses_rt
    );
        return is_load && (rd != '0) && ((rd == rs) || (uses_rt && (rd == rt)));
    endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// hazard_unit_sat_counter: counter that sticks at all-ones instead of wrapping
module hazard_unit_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] cnt_q, cnt_d;

    // Advance on inc unless already saturated
    always_comb cnt_d = (inc && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;

    // Count register, cleared by the active-low asynchronous reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign count = cnt_q;

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: pipeline stall/flush controller with data-memory wait FSM, watchdog and counters
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int STALL_CNT_W = 32,
    parameter int FLUSH_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [REG_NUM_W-1:0]   ifidRSOut,
    input  logic [REG_NUM_W-1:0]   ifidRTOut,
    input  logic                   ifidUsesRT,
    input  logic [REG_NUM_W-1:0]   idexRDOut,
    input  logic                   idexIsLoad,
    input  logic                   exBranchTaken,
    input  logic                   exmemMemReq,
    input  logic                   dmemAck,
    output logic                   dmemReq,
    output logic                   pcWrEnable,
    output logic                   ifidWrEnable,
    output logic                   idexWrEnable,
    output logic                   exmemWrEnable,
    output logic                   memwbWrEnable,
    output logic                   ifidFlush,
    output logic                   idexBubble,
    output logic                   memTimeout,
    output logic [STALL_CNT_W-1:0] stallCycles,
    output logic [FLUSH_CNT_W-1:0] flushCount
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    hz_state_e         state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              frozen, load_use, flush, stall;

    // Next state and watchdog: waitCnt only runs in MEM_WAIT and clears on any exit; an ack beats the timeout
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        if (state_q == HZ_RUN && exmemMemReq && !dmemAck) begin
            state_d = HZ_MEM_WAIT;
        end else if (state_q == HZ_MEM_WAIT) begin
            if (dmemAck)                       state_d = HZ_RUN;
            else if (wait_cnt_q == WAIT_LAST)  state_d = HZ_ERROR;
            else                               wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    // FSM and watchdog registers; reset drops straight back to RUN even mid-wait or in ERROR
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= HZ_RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Pipeline control: freeze beats branch flush, which beats load-use (the squashed ID instruction cannot stall)
    always_comb begin
        frozen        = (state_q == HZ_RUN && exmemMemReq && !dmemAck) ||
                        (state_q == HZ_MEM_WAIT && !dmemAck) || (state_q == HZ_ERROR);
        load_use      = load_use_hit(idexIsLoad, idexRDOut, ifidRSOut, ifidRTOut, ifidUsesRT);
        flush         = !frozen && exBranchTaken;
        stall         = !frozen && !exBranchTaken && load_use;
        pcWrEnable    = !frozen && !stall;
        ifidWrEnable  = !frozen && !stall;
        idexWrEnable  = !frozen;
        exmemWrEnable = !frozen;
        memwbWrEnable = !frozen;
        ifidFlush     = flush;
        idexBubble    = flush || stall;
        dmemReq       = (state_q == HZ_RUN) ? exmemMemReq : (state_q == HZ_MEM_WAIT);
        memTimeout    = (state_q == HZ_ERROR);
    end

    hazard_unit_sat_counter #(.W(STALL_CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (!pcWrEnable),
        .count (stallCycles)
    );

    hazard_unit_sat_counter #(.W(FLUSH_CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush),
        .count (flushCount)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed checks of stalls, flushes, memory waits, timeout and counter saturation
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] ifidRSOut = '0, ifidRTOut = '0, idexRDOut = '0;
    logic       ifidUsesRT = 1'b0, idexIsLoad = 1'b0, exBranchTaken = 1'b0;
    logic       exmemMemReq = 1'b0, dmemAck = 1'b0;
    logic       dmemReq, pcWrEnable, ifidWrEnable, idexWrEnable, exmemWrEnable, memwbWrEnable;
    logic       ifidFlush, idexBubble, memTimeout;
    logic [3:0]  stallCycles;
    logic [15:0] flushCount;

    int checks = 0;
    int errors = 0;

    hazard_unit #(.MEM_TIMEOUT(4), .STALL_CNT_W(4), .FLUSH_CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .ifidRSOut(ifidRSOut), .ifidRTOut(ifidRTOut), .ifidUsesRT(ifidUsesRT),
        .idexRDOut(idexRDOut), .idexIsLoad(idexIsLoad), .exBranchTaken(exBranchTaken),
        .exmemMemReq(exmemMemReq), .dmemAck(dmemAck), .dmemReq(dmemReq),
        .pcWrEnable(pcWrEnable), .ifidWrEnable(ifidWrEnable), .idexWrEnable(idexWrEnable),
        .exmemWrEnable(exmemWrEnable), .memwbWrEnable(memwbWrEnable),
        .ifidFlush(ifidFlush), .idexBubble(idexBubble), .memTimeout(memTimeout),
        .stallCycles(stallCycles), .flushCount(flushCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {pc, ifid, idex, exmem, memwb, flush, bubble}
    function automatic logic [31:0] ctl();
        return {25'd0, pcWrEnable, ifidWrEnable, idexWrEnable, exmemWrEnable, memwbWrEnable,
                ifidFlush, idexBubble};
    endfunction

    initial begin
        // Reset state, outputs evaluate as RUN
        #2;
        chk("rst_ctl", ctl(), 32'b1111100);
        chk("rst_stall", 32'(stallCycles), 0);
        chk("rst_flush", 32'(flushCount), 0);
        chk("rst_timeout", 32'(memTimeout), 0);
        chk("rst_dmemreq", 32'(dmemReq), 0);
        idexIsLoad = 1; idexRDOut = 5; ifidRSOut = 5; #1;
        chk("rst_loaduse_ctl", ctl(), 32'b0011101);
        idexIsLoad = 0; idexRDOut = 0; ifidRSOut = 0;
        tick(); rst = 1'b1; #1;

        // Load-use on rs: one stall cycle, then the bubble clears it
        idexIsLoad = 1; idexRDOut = 5; ifidRSOut = 5; #1;
        chk("lu_rs_ctl", ctl(), 32'b0011101);
        tick();
        chk("lu_rs_stall", 32'(stallCycles), 1);
        idexIsLoad = 0; #1;
        chk("lu_rs_after_ctl", ctl(), 32'b1111100);

        // Load-use on rt, unused rt, and $zero destination
        ifidRSOut = 0; idexIsLoad = 1; idexRDOut = 7; ifidRTOut = 7; ifidUsesRT = 1; #1;
        chk("lu_rt_ctl", ctl(), 32'b0011101);
        ifidUsesRT = 0; #1;
        chk("lu_rt_unused_ctl", ctl(), 32'b1111100);
        idexRDOut = 0; ifidRTOut = 0; ifidUsesRT = 1; #1;
        chk("lu_zero_ctl", ctl(), 32'b1111100);
        tick();
        chk("lu_none_stall", 32'(stallCycles), 1);

        // Branch together with a load-use match: flush wins, no stall
        idexIsLoad = 1; idexRDOut = 5; ifidRSOut = 5; exBranchTaken = 1; #1;
        chk("br_lu_ctl", ctl(), 32'b1111111);
        tick();
        chk("br_flush_cnt", 32'(flushCount), 1);
        chk("br_stall_cnt", 32'(stallCycles), 1);
        idexIsLoad = 0; idexRDOut = 0; ifidRSOut = 0; ifidUsesRT = 0; exBranchTaken = 0;

        // Fresh reset, asynchronous, between edges
        rst = 1'b0; #1;
        chk("rst2_stall", 32'(stallCycles), 0);
        chk("rst2_flush", 32'(flushCount), 0);
        rst = 1'b1;
        tick();

        // Single-cycle access: ack in RUN, no freeze
        exmemMemReq = 1; dmemAck = 1; #1;
        chk("single_ctl", ctl(), 32'b1111100);
        chk("single_dmemreq", 32'(dmemReq), 1);
        tick();
        chk("single_stall", 32'(stallCycles), 0);

        // Memory wait: three ack-less cycles freeze, pipeline moves on the ack cycle
        dmemAck = 0; #1;
        chk("mw0_ctl", ctl(), 32'b0000000);
        chk("mw0_dmemreq", 32'(dmemReq), 1);
        tick();
        chk("mw1_ctl", ctl(), 32'b0000000);
        chk("mw1_dmemreq", 32'(dmemReq), 1);
        exBranchTaken = 1; #1;
        chk("mw1_branch_ctl", ctl(), 32'b0000000);
        tick();
        exBranchTaken = 0; #1;
        chk("mw2_ctl", ctl(), 32'b0000000);
        tick();
        dmemAck = 1; #1;
        chk("mw_ack_ctl", ctl(), 32'b1111100);
        chk("mw_ack_dmemreq", 32'(dmemReq), 1);
        chk("mw_ack_stall", 32'(stallCycles), 3);
        tick();
        exmemMemReq = 0; dmemAck = 0; #1;
        chk("mw_done_dmemreq", 32'(dmemReq), 0);
        chk("mw_done_ctl", ctl(), 32'b1111100);
        chk("mw_done_stall", 32'(stallCycles), 3);
        chk("mw_done_flush", 32'(flushCount), 0);

        // Ack arriving on the last allowed wait cycle beats the timeout
        exmemMemReq = 1;
        repeat (4) tick();
        chk("edge_pre_ack_ctl", ctl(), 32'b0000000);
        dmemAck = 1; #1;
        chk("edge_ack_ctl", ctl(), 32'b1111100);
        tick();
        exmemMemReq = 0; dmemAck = 0; #1;
        chk("edge_timeout", 32'(memTimeout), 0);
        chk("edge_ctl", ctl(), 32'b1111100);
        chk("edge_stall", 32'(stallCycles), 7);

        // Timeout: RUN plus four ack-less MEM_WAIT cycles lands in ERROR
        exmemMemReq = 1;
        repeat (4) tick();
        chk("to_pre_timeout", 32'(memTimeout), 0);
        tick();
        chk("to_timeout", 32'(memTimeout), 1);
        chk("to_dmemreq", 32'(dmemReq), 0);
        chk("to_ctl", ctl(), 32'b0000000);
        chk("to_stall", 32'(stallCycles), 12);
        exmemMemReq = 0; dmemAck = 1; #1;
        chk("to_ack_ctl", ctl(), 32'b0000000);

        // Saturation of the 4-bit stall counter while held in ERROR
        repeat (3) tick();
        chk("sat_15", 32'(stallCycles), 15);
        repeat (5) tick();
        chk("sat_hold", 32'(stallCycles), 15);
        chk("sat_timeout_held", 32'(memTimeout), 1);

        // Asynchronous reset from ERROR
        dmemAck = 0; #2;
        rst = 1'b0; #1;
        chk("err_rst_timeout", 32'(memTimeout), 0);
        chk("err_rst_ctl", ctl(), 32'b1111100);
        chk("err_rst_stall", 32'(stallCycles), 0);
        rst = 1'b1;
        tick();
        chk("post_rst_timeout", 32'(memTimeout), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
